base_system_cpu_cpu_mult_combine: RTL and testbench

//  Downstream stage of the CPU multiplier cell. Consumes the 16x16 partial products
//  (p1=a_lo*b_lo, p2=a_lo*b_hi, p3=a_hi*b_lo) and sums them into the 32-bit mul result.
//  Two-stage valid/stall pipeline (A, W) carries a destination tag; feeds W-stage writeback.

---
 rtl/base_system_cpu_cpu_mult_combine.sv | 181 ++++++++++++++++++
 tb/tb_base_system_cpu_cpu_mult_combine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/base_system_cpu_cpu_mult_combine.sv
// -----------------------------------------------------------------------------
// base_system_cpu_cpu_mult_combine
//
// Purpose:
//   Back end of the CPU multiplier cell. Takes the 16x16 partial products of a
//   32x32 multiply and folds them into the low 32-bit product word. The module
//   is a two-stage valid/stall pipeline (A, then W) that carries a destination
//   register tag alongside the data, so the W stage can drive writeback
//   directly. The accept-to-W_mul_valid latency is two clocks, and the pipeline
//   sustains one operation per clock.
//
// Optional feature:
//   MUL_HI_EN - when defined, the module also takes the a_hi*b_hi partial
//               product and produces the high 32-bit product word.
//
// Parameters:
//   DST_W  width of the destination register tag
//   CNT_W  width of the saturating completed-operation counter
//
// Ports:
//   clk              in   rising-edge clock
//   reset_n          in   asynchronous active-low reset
//   M_mul_cell_p1    in   a[15:0]  * b[15:0]
//   M_mul_cell_p2    in   a[15:0]  * b[31:16]
//   M_mul_cell_p3    in   a[31:16] * b[15:0]
//   M_mul_cell_p4    in   a[31:16] * b[31:16]        (MUL_HI_EN only)
//   M_mul_valid      in   partial products and tag are valid
//   M_mul_dst        in   destination register tag
//   M_flush          in   kill the incoming op and any op held in stage A
//   W_stall          in   writeback not ready; hold the W outputs
//   M_mul_ready      out  stage A can accept an op this cycle
//   W_mul_valid      out  W_mul_result / W_mul_dst are valid
//   W_mul_result     out  low 32 bits of a*b
//   W_mul_result_hi  out  high 32 bits of a*b        (MUL_HI_EN only)
//   W_mul_dst        out  tag belonging to W_mul_result
//   mul_busy         out  an op is held in stage A or stage W
//   mul_done_cnt     out  saturating count of results retired from W
// -----------------------------------------------------------------------------
module base_system_cpu_cpu_mult_combine #(
  parameter int DST_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
`ifdef MUL_HI_EN
  input  logic [31:0]      M_mul_cell_p4,
  output logic [31:0]      W_mul_result_hi,
`endif
  input  logic             M_mul_valid,
  input  logic [DST_W-1:0] M_mul_dst,
  input  logic             M_flush,
  input  logic             W_stall,
  output logic             M_mul_ready,
  output logic             W_mul_valid,
  output logic [31:0]      W_mul_result,
  output logic [DST_W-1:0] W_mul_dst,
  output logic             mul_busy,
  output logic [CNT_W-1:0] mul_done_cnt
);

  // Stage A state
  logic             a_valid_q;
  logic             a_valid_d;
  logic [31:0]      a_p1_q;
  logic [32:0]      a_mid_q;
  logic [DST_W-1:0] a_dst_q;

  // Stage W state
  logic             w_valid_q;
  logic [31:0]      w_result_q;
  logic [DST_W-1:0] w_dst_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             w_adv;
  logic             a_move;
  logic             accept;
  logic             retire;
  logic [32:0]      mid_d;
  logic [32:0]      lo33;

  // The two cross products share the same 2^16 weight, so they are summed
  // early (in A) to leave a single 33-bit add for the W stage.
  assign mid_d  = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
  assign lo33   = {1'b0, a_p1_q} + {1'b0, a_mid_q[15:0], 16'h0000};

  // W frees up when it is empty or its result is being taken this cycle.
  assign w_adv  = ~w_valid_q | ~W_stall;
  assign a_move = a_valid_q & w_adv;
  // A can take a new op if empty or if its current op moves on this edge.
  assign M_mul_ready = ~a_valid_q | w_adv;
  assign accept = M_mul_valid & M_mul_ready & ~M_flush;
  assign retire = w_valid_q & ~W_stall;

  // A flush kills an op that would otherwise stay in A; an op leaving A on
  // the same edge has already reached W and survives.
  always_comb begin
    a_valid_d = a_valid_q;
    if (accept) begin
      a_valid_d = 1'b1;
    end else if (a_move || M_flush) begin
      a_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef MUL_HI_EN
  logic [31:0] a_p4_q;
  logic [31:0] w_hi_q;
  logic [31:0] hi_d;

  assign hi_d = a_p4_q + {15'h0000, a_mid_q[32:16]} + {31'h0000_0000, lo33[32]};
  assign W_mul_result_hi = w_hi_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_p4_q <= '0;
      w_hi_q <= '0;
    end else begin
      if (accept) begin
        a_p4_q <= M_mul_cell_p4;
      end
      if (w_adv && a_valid_q) begin
        w_hi_q <= hi_d;
      end
    end
  end
`else
  // Only the low word is produced, so the carries into the high word are
  // simply dropped.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{a_mid_q[32:16], lo33[32]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q  <= 1'b0;
      a_p1_q     <= '0;
      a_mid_q    <= '0;
      a_dst_q    <= '0;
      w_valid_q  <= 1'b0;
      w_result_q <= '0;
      w_dst_q    <= '0;
      cnt_q      <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      if (accept) begin
        a_p1_q  <= M_mul_cell_p1;
        a_mid_q <= mid_d;
        a_dst_q <= M_mul_dst;
      end
      // W data only changes when a real op arrives, so the outputs stay
      // stable while stalled and after a retire into an empty A.
      if (w_adv) begin
        w_valid_q <= a_valid_q;
        if (a_valid_q) begin
          w_result_q <= lo33[31:0];
          w_dst_q    <= a_dst_q;
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign W_mul_valid  = w_valid_q;
  assign W_mul_result = w_result_q;
  assign W_mul_dst    = w_dst_q;
  assign mul_busy     = a_valid_q | w_valid_q;
  assign mul_done_cnt = cnt_q;

endmodule

// File: tb/tb_base_system_cpu_cpu_mult_combine.sv
// Testbench for base_system_cpu_cpu_mult_combine: fixed vectors, hand-written
// stall/flush/reset sequences and random traffic, all checked against an
// in-order transaction-level model of the two-slot pipeline.
module tb_base_system_cpu_cpu_mult_combine;

  localparam int DST_W = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] p1, p2, p3, p4;
  logic        vld, flush, stall;
  logic [4:0]  dst;

  logic        ready, wv, busy;
  logic [31:0] wres;
  logic [4:0]  wdst;
  logic [15:0] cnt;

  logic        ready2, wv2, busy2;
  logic [31:0] wres2;
  logic [4:0]  wdst2;
  logic [1:0]  cnt2;

`ifdef MUL_HI_EN
  logic [31:0] whi, whi2;
`endif

  always #5 clk = ~clk;

  base_system_cpu_cpu_mult_combine #(.DST_W(DST_W), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
`ifdef MUL_HI_EN
    .M_mul_cell_p4(p4), .W_mul_result_hi(whi),
`endif
    .M_mul_valid(vld), .M_mul_dst(dst), .M_flush(flush), .W_stall(stall),
    .M_mul_ready(ready), .W_mul_valid(wv), .W_mul_result(wres),
    .W_mul_dst(wdst), .mul_busy(busy), .mul_done_cnt(cnt)
  );

  // Narrow counter instance so saturation is reachable quickly.
  base_system_cpu_cpu_mult_combine #(.DST_W(DST_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
`ifdef MUL_HI_EN
    .M_mul_cell_p4(p4), .W_mul_result_hi(whi2),
`endif
    .M_mul_valid(vld), .M_mul_dst(dst), .M_flush(flush), .W_stall(stall),
    .M_mul_ready(ready2), .W_mul_valid(wv2), .W_mul_result(wres2),
    .W_mul_dst(wdst2), .mul_busy(busy2), .mul_done_cnt(cnt2)
  );

  // Model: ops in program order; in_w marks the op sitting in the W slot.
  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [4:0]  dst;
    bit          in_w;
  } op_t;

  typedef struct {
    logic [31:0] p1, p2, p3, p4;
    logic [4:0]  dst;
    logic [31:0] eres, ehi;
  } vec_t;

  op_t q[$];
  int  cnt_m, cnt2_m;
  int  n_vec, n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit exp_wv;
    exp_wv = (q.size() > 0) && q[0].in_w;
    chk("w_valid", wv, exp_wv);
    chk("w_valid2", wv2, exp_wv);
    if (exp_wv) begin
      chk("w_result", wres, q[0].res);
      chk("w_dst", wdst, q[0].dst);
`ifdef MUL_HI_EN
      chk("w_result_hi", whi, q[0].hi);
`endif
    end
    chk("busy", busy, q.size() > 0);
    chk("done_cnt", cnt, cnt_m);
    chk("done_cnt_sat", cnt2, cnt2_m);
  endtask

  // One clock: drive inputs, check ready, take the edge, update the model,
  // check registered outputs. Prints one line per accepted transaction.
  task automatic cycle(input bit v, input bit f, input bit s,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] a3, input logic [31:0] a4,
                       input logic [4:0] d,
                       input logic [31:0] eres, input logic [31:0] ehi);
    bit a_full, w_full, w_adv, rdy;
    op_t op;
    vld = v; flush = f; stall = s;
    p1 = a1; p2 = a2; p3 = a3; p4 = a4; dst = d;
    #1;
    a_full = (q.size() > 0) && !q[q.size()-1].in_w;
    w_full = (q.size() > 0) && q[0].in_w;
    w_adv  = !w_full || !s;
    rdy    = !a_full || w_adv;
    chk("ready", ready, rdy);
    chk("ready2", ready2, rdy);
    @(posedge clk);
    if (w_full && !s) begin
      void'(q.pop_front());
      if (cnt_m < 65535) cnt_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
    if (a_full) begin
      if (w_adv) q[q.size()-1].in_w = 1'b1;
      else if (f) void'(q.pop_back());
    end
    if (v && rdy && !f) begin
      op.res = eres; op.hi = ehi; op.dst = d; op.in_w = 1'b0;
      q.push_back(op);
      $display("accept dst=%0d p1=%h p2=%h p3=%h exp=%h", d, a1, a2, a3, eres);
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit f, input bit s);
    cycle(1'b0, f, s, '0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic op(input bit f, input bit s, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] d);
    logic [63:0] prod;
    logic [31:0] q1, q2, q3, q4;
    prod = {32'h0, a} * {32'h0, b};
    q1 = {16'h0, a[15:0]}  * {16'h0, b[15:0]};
    q2 = {16'h0, a[15:0]}  * {16'h0, b[31:16]};
    q3 = {16'h0, a[31:16]} * {16'h0, b[15:0]};
    q4 = {16'h0, a[31:16]} * {16'h0, b[31:16]};
    cycle(1'b1, f, s, q1, q2, q3, q4, d, prod[31:0], prod[63:32]);
  endtask

  vec_t vecs[8];

  initial begin
    n_vec = 0; n_err = 0; cnt_m = 0; cnt2_m = 0;
    vld = 0; flush = 0; stall = 0; p1 = 0; p2 = 0; p3 = 0; p4 = 0; dst = 0;

    vecs[0] = '{32'd15, 32'd0, 32'd0, 32'd0, 5'd3, 32'd15, 32'd0};
    vecs[1] = '{32'd1, 32'd1, 32'd1, 32'd1, 5'd1, 32'h0002_0001, 32'd1};
    vecs[2] = '{32'd1, 32'd1, 32'd1, 32'd1, 5'd2, 32'h0002_0001, 32'd1};
    vecs[3] = '{32'd1, 32'd1, 32'd1, 32'd1, 5'd4, 32'h0002_0001, 32'd1};
    vecs[4] = '{32'd1, 32'd1, 32'd1, 32'd1, 5'd5, 32'h0002_0001, 32'd1};
    vecs[5] = '{32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 5'd7,
                32'h0000_0001, 32'hFFFF_FFFE};
    vecs[6] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd31,
                32'hFFFE_0000, 32'h0001_FFFF};
    vecs[7] = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 5'd0, 32'h0000_FFFF, 32'h1};

    // Reset state
    reset_n = 1'b0;
    #12;
    chk("rst_w_valid", wv, 1'b0);
    chk("rst_result", wres, 32'd0);
    chk("rst_dst", wdst, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", cnt, 16'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", ready, 1'b1);

    // Single op: result two clocks after accept.
    cycle(1'b1, 1'b0, 1'b0, vecs[0].p1, vecs[0].p2, vecs[0].p3, vecs[0].p4,
          vecs[0].dst, vecs[0].eres, vecs[0].ehi);
    chk("lat_not_yet", wv, 1'b0);
    idle(1'b0, 1'b0);
    chk("lat_2clk_valid", wv, 1'b1);
    chk("lat_2clk_result", wres, 32'd15);
    idle(1'b0, 1'b0);

    // Remaining table entries back to back, then drain.
    for (int i = 1; i < 8; i++)
      cycle(1'b1, 1'b0, 1'b0, vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].p4,
            vecs[i].dst, vecs[i].eres, vecs[i].ehi);
    repeat (3) idle(1'b0, 1'b0);
    chk("cnt_after_table", cnt, 16'd8);
    chk("cnt_saturated", cnt2, 2'd3);

    // Stall with both stages full: no accept, outputs held, order kept.
    op(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10);
    op(1'b0, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF, 5'd11);
    repeat (4) idle(1'b0, 1'b1);
    op(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 5'd12);
    chk("stall_ready_low", ready, 1'b0);
    chk("stall_cnt_held", cnt, 16'd8);
    repeat (3) idle(1'b0, 1'b0);
    chk("stall_cnt_after", cnt, 16'd10);

    // Flush with A full, W empty, plus a new op: A op survives, new op dropped.
    op(1'b0, 1'b0, 32'h0000_0003, 32'h0000_0005, 5'd20);
    op(1'b1, 1'b0, 32'h0000_0007, 32'h0000_0009, 5'd21);
    repeat (3) idle(1'b0, 1'b0);
    chk("flush_cnt", cnt, 16'd11);

    // Flush with W stalled: the op stuck in A is killed.
    op(1'b0, 1'b1, 32'hFFFF_0000, 32'h0001_FFFF, 5'd22);
    op(1'b0, 1'b1, 32'h0000_FFFF, 32'hFFFF_0001, 5'd23);
    idle(1'b1, 1'b1);
    repeat (3) idle(1'b0, 1'b0);
    chk("flush_kill_cnt", cnt, 16'd12);
    idle(1'b1, 1'b0);  // flush on an empty pipe

    // Reset with both stages full.
    op(1'b0, 1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd24);
    op(1'b0, 1'b1, 32'h5555_5555, 32'hAAAA_AAAA, 5'd25);
    vld = 1'b0;
    reset_n = 1'b0;
    #1;
    q.delete(); cnt_m = 0; cnt2_m = 0;
    chk("rst2_w_valid", wv, 1'b0);
    chk("rst2_result", wres, 32'd0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_cnt", cnt, 16'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) idle(1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit rv, rf, rs;
      rv = ($urandom_range(0, 9) < 7);
      rf = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 9) < 3);
      op(rf, rs, $urandom, $urandom, 5'($urandom_range(0, 31)));
      if (!rv) idle(1'b0, rs);
    end
    repeat (4) idle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
